// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
// ex_muldiv: multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Multiplies finish after MUL_LAT cycles; divides use radix-2 restoring iterations plus a sign-fix cycle.
module ex_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic             is_sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             read_hilo,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] F_NOP  = 3'b000;
  localparam logic [2:0] F_MULT = 3'b001;
  localparam logic [2:0] F_DIV  = 3'b010;
  localparam logic [2:0] F_MADD = 3'b011;
  localparam logic [2:0] F_MSUB = 3'b100;
  localparam logic [2:0] F_MTHI = 3'b101;
  localparam logic [2:0] F_MTLO = 3'b110;
  localparam logic [2:0] F_RSVD = 3'b111;

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("ex_muldiv: WIDTH must be even and at least 4");
  end
  if (MUL_LAT < 1) begin : g_bad_lat
    $error("ex_muldiv: MUL_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [2:0]       op_reg, op_next;
  logic             sign_reg, sign_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] dvsr_reg, dvsr_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic               is_op;
  logic               accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   q_signed, r_signed;

  assign is_op     = (func != F_NOP) && (func != F_RSVD);
  assign accept    = (state_reg == IDLE) && start && !cancel && is_op;
  assign stall_req = busy_reg && (read_hilo || (start && is_op));

  assign abs_a = (is_sign && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_sign && b[WIDTH-1]) ? -b : b;

  // Sign-extending to 2*WIDTH lets one modular multiplier serve both signed and unsigned.
  assign a_ext = {{WIDTH{sign_reg & a_reg[WIDTH-1]}}, a_reg};
  assign b_ext = {{WIDTH{sign_reg & b_reg[WIDTH-1]}}, b_reg};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi_reg, lo_reg};

  // The dividend shifts out of quot_reg's top as quotient bits shift into its bottom.
  assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvsr_reg};

  assign q_signed = (sign_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? -quot_reg : quot_reg;
  assign r_signed = (sign_reg && a_reg[WIDTH-1]) ? -rem_reg : rem_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    sign_next  = sign_reg;
    rem_next   = rem_reg;
    quot_next  = quot_reg;
    dvsr_next  = dvsr_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next   = func;
          sign_next = is_sign;
          a_next    = a;
          b_next    = b;
          cnt_next  = '0;
          case (func)
            F_MTHI: hi_next = a;
            F_MTLO: lo_next = a;
            F_DIV: begin
              state_next = DIV;
              quot_next  = abs_a;
              rem_next   = '0;
              dvsr_next  = abs_b;
            end
            default: state_next = MUL;
          endcase
        end
      end

      MUL: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(MUL_LAT - 1)) begin
          case (op_reg)
            F_MADD:  {hi_next, lo_next} = acc + prod;
            F_MSUB:  {hi_next, lo_next} = acc - prod;
            default: {hi_next, lo_next} = prod;
          endcase
          done_next  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DIV: begin
        if (cancel) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, dvsr_reg}) : rem_shift[WIDTH-1:0];
          quot_next = {quot_reg[WIDTH-2:0], rem_ge};
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_next = FIX;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      FIX: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          // Divide by zero returns all ones and the raw dividend regardless of signedness.
          if (b_reg == '0) begin
            lo_next = '1;
            hi_next = a_reg;
          end else begin
            lo_next = q_signed;
            hi_next = r_signed;
          end
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= F_NOP;
      sign_reg  <= 1'b0;
      rem_reg   <= '0;
      quot_reg  <= '0;
      dvsr_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      sign_reg  <= sign_next;
      rem_reg   <= rem_next;
      quot_reg  <= quot_next;
      dvsr_reg  <= dvsr_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
`timescale 1ns/1ps
// tb_ex_muldiv: directed vector table, hand-written cancel/stall/reset sequences, and
// randomized operations checked against an arithmetic model of HI/LO.
module tb_ex_muldiv;
  localparam int W  = 32;
  localparam int ML = 2;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, DIV = 3'd2, MADD = 3'd3;
  localparam logic [2:0] MSUB = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic         clk = 1'b0;
  logic         rst, start, is_sign, cancel, read_hilo;
  logic [2:0]   func;
  logic [W-1:0] a, b;
  logic         busy, done, stall_req;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] m_hi, m_lo;

  ex_muldiv #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign),
    .a(a), .b(b), .cancel(cancel), .read_hilo(read_hilo),
    .busy(busy), .done(done), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]   f;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  task automatic model(input logic [2:0] f, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [2*W-1:0] p, acc;
    sx  = s ? longint'($signed(x)) : longint'(x);
    sy  = s ? longint'($signed(y)) : longint'(y);
    p   = 64'(sx * sy);
    acc = {m_hi, m_lo};
    case (f)
      MULT: {m_hi, m_lo} = p;
      MADD: {m_hi, m_lo} = acc + p;
      MSUB: {m_hi, m_lo} = acc - p;
      MTHI: m_hi = x;
      MTLO: m_lo = x;
      DIV: begin
        if (y == '0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = x;
        end else begin
          m_lo = W'(sx / sy);
          m_hi = W'(sx % sy);
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] specials[5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return specials[$urandom_range(0, 4)];
      1:       return W'($urandom_range(0, 40)) - W'(20);
      default: return W'($urandom);
    endcase
  endfunction

  // Issues one op at the current negedge and follows it to completion; returns in the done cycle.
  task automatic do_op(input string tag, input logic [2:0] f, input logic s,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    int exp_lat;
    bit multi;
    multi   = (f == MULT) || (f == DIV) || (f == MADD) || (f == MSUB);
    exp_lat = (f == DIV) ? W + 1 : ML;
    start = 1'b1; func = f; is_sign = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0; func = NOP; is_sign = ~s; a = W'($urandom); b = W'($urandom);
    n = 0;
    if (multi) begin
      while (busy === 1'b1 && n < 200) begin
        check({tag, " done_low"}, 64'(done), 64'(0));
        read_hilo = 1'($urandom_range(0, 1));
        #1;
        check({tag, " stall"}, 64'(stall_req), 64'(read_hilo));
        read_hilo = 1'b0;
        @(negedge clk);
        n++;
      end
      check({tag, " busy_cycles"}, 64'(n), 64'(exp_lat));
      check({tag, " done"}, 64'(done), 64'(1));
    end else begin
      check({tag, " busy"}, 64'(busy), 64'(0));
      check({tag, " done"}, 64'(done), 64'(0));
    end
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int n;
    logic [2:0]   ops[6];
    logic [2:0]   f;
    logic         s;
    logic [W-1:0] x, y;

    vecs[0]  = '{MULT, 1'b0, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1]  = '{DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2]  = '{DIV,  1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[3]  = '{DIV,  1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[4]  = '{DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[5]  = '{MTHI, 1'b0, 32'h0,         32'h0,         32'h0,         32'h8000_0000};
    vecs[6]  = '{MTLO, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF};
    vecs[7]  = '{MADD, 1'b0, 32'd1,         32'd1,         32'h1,         32'h0};
    vecs[8]  = '{MSUB, 1'b0, 32'd1,         32'd1,         32'h0,         32'hFFFF_FFFF};
    vecs[9]  = '{MULT, 1'b1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[10] = '{DIV,  1'b0, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[11] = '{DIV,  1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[12] = '{DIV,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF};
    vecs[13] = '{MADD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'h0};
    vecs[14] = '{MSUB, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF};

    rst = 1'b0; start = 1'b0; func = NOP; is_sign = 1'b0;
    a = '0; b = '0; cancel = 1'b0; read_hilo = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset stall", 64'(stall_req), 64'(0));
    read_hilo = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Directed table; ops run back to back, each issued in the previous op's done cycle.
    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].s, vecs[i].a, vecs[i].b,
            vecs[i].exp_hi, vecs[i].exp_lo);
    @(negedge clk);
    check("vec_tail done_low", 64'(done), 64'(0));

    // DIV with a MULT start presented while busy: MULT must be ignored.
    start = 1'b1; func = DIV; is_sign = 1'b0; a = 32'd100; b = 32'd7;
    @(negedge clk);
    func = MULT; a = 32'd3; b = 32'd3;
    #1;
    check("ign busy", 64'(busy), 64'(1));
    check("ign stall_start", 64'(stall_req), 64'(1));
    @(negedge clk);
    start = 1'b0; func = NOP;
    #1;
    check("ign stall_idle_inputs", 64'(stall_req), 64'(0));
    read_hilo = 1'b1;
    #1;
    check("ign stall_read_hilo", 64'(stall_req), 64'(1));
    read_hilo = 1'b0;
    n = 2;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ign busy_cycles", 64'(n - 1), 64'(W + 1));
    check("ign done", 64'(done), 64'(1));
    check("ign hi", 64'(hi), 64'(2));
    check("ign lo", 64'(lo), 64'(14));
    @(negedge clk);
    check("ign no_mult busy", 64'(busy), 64'(0));
    check("ign done_pulse", 64'(done), 64'(0));

    // Cancel a DIV at busy cycle 10.
    start = 1'b1; func = DIV; is_sign = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; func = NOP;
    repeat (9) @(negedge clk);
    check("cxl10 busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cxl10 busy", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("cxl10 no_done", 64'(done), 64'(0));
      @(negedge clk);
    end
    check("cxl10 hi", 64'(hi), 64'(2));
    check("cxl10 lo", 64'(lo), 64'(14));

    // Cancel in the final DIV busy cycle (FIX): no update.
    start = 1'b1; func = DIV; is_sign = 1'b0; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 1'b0; func = NOP;
    repeat (W) @(negedge clk);
    check("cxlfix busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cxlfix busy", 64'(busy), 64'(0));
    check("cxlfix done", 64'(done), 64'(0));
    check("cxlfix hilo", {hi, lo}, {32'd2, 32'd14});

    // Cancel in the final MULT busy cycle.
    start = 1'b1; func = MULT; is_sign = 1'b0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; func = NOP;
    repeat (ML - 1) @(negedge clk);
    check("cxlmul busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cxlmul busy", 64'(busy), 64'(0));
    check("cxlmul done", 64'(done), 64'(0));
    check("cxlmul hilo", {hi, lo}, {32'd2, 32'd14});

    // cancel in the issue cycle kills the issue.
    start = 1'b1; func = MTLO; a = 32'hDEAD; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; func = NOP; cancel = 1'b0;
    check("cxlissue lo", 64'(lo), 64'(14));
    check("cxlissue busy", 64'(busy), 64'(0));

    // Asynchronous reset between edges, mid-MULT.
    start = 1'b1; func = MULT; is_sign = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; func = NOP;
    #2 rst = 1'b0;
    #1;
    check("arst busy", 64'(busy), 64'(0));
    check("arst done", 64'(done), 64'(0));
    check("arst hi", 64'(hi), 64'(0));
    check("arst lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op("mtlo_after_rst", MTLO, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h1234);

    // Randomized ops against the model.
    m_hi = 32'h0;
    m_lo = 32'h1234;
    ops = '{MULT, DIV, MADD, MSUB, MTHI, MTLO};
    for (int i = 0; i < 60; i++) begin
      f = ops[$urandom_range(0, 5)];
      s = 1'($urandom_range(0, 1));
      x = rnd_operand();
      y = rnd_operand();
      model(f, s, x, y);
      do_op($sformatf("rnd%0d f=%0d s=%0d a=%h b=%h", i, f, s, x, y), f, s, x, y, m_hi, m_lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated in the EX stage beside the ALU. It executes MULT/DIV/MADD/MSUB/MTHI/MTLO issued from EX and raises a stall request while an operation is in flight. Its HI/LO outputs feed the EX result mux for MFHI/MFLO.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- MUL_LAT, 2: multiply busy cycles; must be ≥ 1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  issue strobe from EX; qualified by `func != NOP`.
- func  in  3  operation code:
  - 000 NOP, 001 MULT, 010 DIV, 011 MADD, 100 MSUB;
  - 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
- is_sign  in  1  signed operands for MULT/DIV/MADD/MSUB.
- a, b  in  WIDTH  operands (already forwarded); a is the dividend or MTHI/MTLO source.
- cancel  in  1  EX flush; kills the issue in the same cycle and any in-flight op.
- read_hilo  in  1  EX currently holds MFHI/MFLO.
- busy  out  1  registered; high while an op is in flight.
- done  out  1  registered one-cycle pulse; HI/LO updated by a multi-cycle op.
- stall_req  out  1  combinational: `busy && (read_hilo || (start && func != NOP))`.
- hi, lo  out  WIDTH  registered architectural HI and LO.

## Operation
**FSM states:** IDLE, MUL, DIV, FIX.

**Accept rule.** An op is accepted when all of the following hold:
- state is IDLE;
- start = 1 and cancel = 0;
- func is not NOP or reserved.

Starts that arrive while busy are ignored. stall_req holds the EX stage until busy drops.

**MTHI / MTLO.** hi <= a or lo <= a at the accepting edge. No busy, no done.

**MULT.** Computes the 2·WIDTH product of a·b, signed or unsigned per is_sign.
- IDLE → MUL; a cycle counter counts MUL_LAT cycles.
- On the last cycle: {hi,lo} <= product, then → IDLE.

**MADD / MSUB.** Same path and latency as MULT; {hi,lo} <= {hi,lo} ± product, modulo 2^(2·WIDTH).

**DIV.** Radix-2 restoring division on absolute values.
- IDLE → DIV for WIDTH iteration cycles, one quotient bit per cycle, then → FIX for 1 cycle.
- FIX applies signs (when is_sign): quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- FIX writes lo <= quotient, hi <= remainder, then → IDLE.
- Divide by zero: lo <= all ones, hi <= a (both signed and unsigned).
- Signed MIN / −1: lo <= MIN, hi <= 0 (wraps, no trap).

**Operand capture.** Operands and is_sign are latched at acceptance; later changes on a/b have no effect.

**cancel while busy.** → IDLE at the next edge. HI/LO unchanged, no done pulse, partial results discarded.

**Reset (any time, including mid-op):** state IDLE, hi = lo = 0, busy = 0, done = 0, counters = 0.

## Timing
- Acceptance at edge k: busy = 1 from cycle k+1.
- MULT/MADD/MSUB: busy for MUL_LAT cycles. New hi/lo and done = 1 appear in cycle k+MUL_LAT+1, with busy = 0 in that cycle.
- DIV: busy for WIDTH+1 cycles (WIDTH iterations + FIX). Results and done appear in cycle k+WIDTH+2.
- A new op may be accepted in the cycle where done = 1, giving back-to-back issue.
- MFHI/MFLO forwarding: in the done cycle, hi/lo already hold the new value; the EX mux reads them directly.
- cancel and done never coincide for the same op. cancel in the final busy cycle wins: no update.
- stall_req is purely combinational from busy and the inputs, with no registered delay.

## Test plan
- **Unsigned MULT.** WIDTH=32, MUL_LAT=2, a=0xFFFF_FFFF, b=2, is_sign=0.
  - Expect busy for 2 cycles, then hi=0x0000_0001, lo=0xFFFF_FFFE, with done pulsing once.
- **Signed DIV.** a=−7 (0xFFFF_FFF9), b=2, is_sign=1.
  - Expect busy for 33 cycles, then lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1).
- **Divide-by-zero and MIN/−1.**
  - a=5, b=0: expect lo=0xFFFF_FFFF, hi=5.
  - a=0x8000_0000, b=0xFFFF_FFFF signed: expect lo=0x8000_0000, hi=0.
- **MADD then MSUB.**
  - Preload via MTHI=0, MTLO=0xFFFF_FFFF, then MADD 1·1: expect hi=1, lo=0.
  - MSUB 1·1: expect hi=0, lo=0xFFFF_FFFF.
- **Stall and cancel.**
  - DIV issued, then start MULT while busy: expect stall_req=1 and the MULT ignored.
  - Assert cancel at busy cycle 10: expect busy=0 next cycle, hi/lo unchanged, no done.
  - read_hilo while busy: expect stall_req=1.
- **Async reset mid-MULT.** Drop rst low between edges: expect hi=lo=0 and busy=0 immediately. After release, MTLO a=0x1234 sets lo=0x1234 with no busy.
